morse_key_sequencer: RTL and testbench

Front-end controller for the Morse letter decoder. Converts a single raw telegraph-key input into the decoder's 2-bit symbol stream: one-cycle dot (01) and dash (10) pulses timed from press duration, and one-cycle send (11) pulses after an inter-letter gap. Holds 00 (idle) at all other times. Counts committed letters and stops issuing symbols once the decoder's 10-letter buffer is full.

---
 rtl/morse_key_sequencer_if.sv | 33 +++
 rtl/morse_key_sequencer.sv | 170 +++++++++++++++++
 tb/tb_morse_key_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_key_sequencer_if.sv
// morse_key_sequencer_if: key input and decoder-side outputs of the Morse key sequencer.
//
// Signalling: there is no valid/ready pair on this bus. key_in is a raw level
// that the sequencer samples every cycle. symbol_out is a free-running stream:
// a non-00 value is valid for exactly one cycle and the consumer must accept it
// in that cycle, since it is never held or repeated. letter_count, full, busy and
// state_dbg are registered levels that may be sampled at any time.
interface morse_key_sequencer_if;
  logic       key_in;
  logic [1:0] symbol_out;
  logic [3:0] letter_count;
  logic       full;
  logic       busy;
  logic [1:0] state_dbg;

  modport master (
    input  key_in,
    output symbol_out,
    output letter_count,
    output full,
    output busy,
    output state_dbg
  );

  modport slave (
    output key_in,
    input  symbol_out,
    input  letter_count,
    input  full,
    input  busy,
    input  state_dbg
  );
endinterface

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: turns a raw telegraph key into the decoder's 2-bit
// symbol stream (01 dot, 10 dash, 11 send, 00 idle) and counts letters sent.
//
// Optional feature: define MORSE_DEBOUNCE_EN to insert a debounce filter after
// the synchronizer. The DEBOUNCE_CYCLES parameter exists only in that build.
module morse_key_sequencer #(
  parameter int unsigned DOT_MAX         = 4,
  parameter int unsigned LETTER_GAP      = 8,
  parameter int unsigned MAX_SYMBOLS     = 4,
  parameter int unsigned MAX_LETTERS     = 10,
`ifdef MORSE_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 3,
`endif
  parameter int unsigned CNT_W           = 16
) (
  input logic                    clk,
  input logic                    reset,
  morse_key_sequencer_if.master  bus
);

  localparam int unsigned SYM_W = $clog2(MAX_SYMBOLS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP);
  localparam logic [SYM_W-1:0] MAX_SYM_C    = SYM_W'(MAX_SYMBOLS);
  localparam logic [3:0]       MAX_LC       = 4'(MAX_LETTERS);

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_SEND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, key_q, key_s;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [1:0]       symbol_q, symbol_d;
  logic [3:0]       letters_q, letters_d;
  logic             full_q, busy_q;

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      sync1_q <= bus.key_in;
      key_q   <= sync1_q;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q;
  logic            key_s_q;

  // Debounce: adopt key_q once it has differed from the filtered value for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old value restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      key_s_q  <= 1'b0;
    end else if (key_q == key_s_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_q <= '0;
      key_s_q  <= key_q;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign key_s = key_s_q;
`else
  assign key_s = key_q;
`endif

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      symbol_q    <= SYM_IDLE;
      letters_q   <= 4'd0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      symbol_q    <= symbol_d;
      letters_q   <= letters_d;
      full_q      <= (letters_d == MAX_LC);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Next-state logic: press timing, symbol emission, letter gap and send.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    symbol_d    = SYM_IDLE;
    letters_d   = letters_q;

    unique case (state_q)
      S_IDLE: begin
        sym_cnt_d = '0;
        // Once the decoder buffer is full the key is ignored until reset.
        if (key_s && !full_q) begin
          state_d     = S_PRESS;
          press_cnt_d = CNT_ONE;
        end
      end

      S_PRESS: begin
        if (key_s) begin
          if (press_cnt_q != '1) press_cnt_d = press_cnt_q + CNT_ONE;
        end else begin
          symbol_d  = (press_cnt_q <= DOT_MAX_C) ? SYM_DOT : SYM_DASH;
          sym_cnt_d = sym_cnt_q + SYM_W'(1);
          gap_cnt_d = CNT_ONE;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        // The send takes priority over a press arriving in the same cycle.
        if (gap_cnt_q >= LETTER_GAP_C) begin
          symbol_d  = SYM_SEND;
          letters_d = (letters_q == MAX_LC) ? letters_q : letters_q + 4'd1;
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (key_s && (sym_cnt_q < MAX_SYM_C)) begin
          state_d     = S_PRESS;
          press_cnt_d = CNT_ONE;
          gap_cnt_d   = '0;
        end else if (!key_s) begin
          if (gap_cnt_q != '1) gap_cnt_d = gap_cnt_q + CNT_ONE;
        end
        // A press beyond MAX_SYMBOLS leaves gap_cnt holding.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.symbol_out   = symbol_q;
  assign bus.letter_count = letters_q;
  assign bus.full         = full_q;
  assign bus.busy         = busy_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb_morse_key_sequencer: directed table, hand-written corner sequences and
// random key traces for morse_key_sequencer, against a trace-level model.
`timescale 1ns/1ps
module tb_morse_key_sequencer;

  localparam int DOT_MAX     = 4;
  localparam int LETTER_GAP  = 8;
  localparam int MAX_SYMBOLS = 4;
  localparam int MAX_LETTERS = 10;
  localparam int DEB_CYCLES  = 3;
  localparam int MAXN        = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  morse_key_sequencer_if bus_if ();

  morse_key_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         kin [MAXN];
  bit         ks  [MAXN];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [63:0] pat;   // {hi,lo} nibble pairs, first pair in the low byte
    int          nsym;  // expected number of non-idle symbols
    logic [15:0] seq;   // expected symbols, first in bits [1:0]
    logic [3:0]  cnt;   // expected final letter_count
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the whole key trace: key_s is key_in delayed through the
  // synchronizer (and filter), presses are run lengths of key_s high, and a
  // letter closes once LETTER_GAP-1 low cycles follow the first low cycle.
  // Result per cycle: {symbol_out, letter_count, full, busy}.
  function automatic void build_model(input int n);
    bit         kq   [MAXN];
    logic [1:0] sym  [MAXN];
    logic [3:0] cnt  [MAXN];
    bit         busy [MAXN];
    int t, t0, t1, g, lows, syms, letters, nxt, first;
    for (int i = 0; i < n; i++) begin
      kq[i]   = (i >= 2) ? kin[i-2] : 1'b0;
      sym[i]  = 2'b00;
      cnt[i]  = 4'd0;
      busy[i] = 1'b0;
    end
`ifdef MORSE_DEBOUNCE_EN
    ks[0] = 1'b0;
    for (int i = 1; i < n; i++) begin
      bit stable;
      stable = (i >= DEB_CYCLES);
      for (int j = 2; j <= DEB_CYCLES; j++)
        if (stable && kq[i-j] != kq[i-1]) stable = 1'b0;
      ks[i] = stable ? kq[i-1] : ks[i-1];
    end
`else
    for (int i = 0; i < n; i++) ks[i] = kq[i];
`endif
    letters = 0;
    t = 0;
    while (t < n && letters < MAX_LETTERS) begin
      while (t < n && !ks[t]) t++;
      if (t >= n) break;
      first = t;
      nxt   = t;
      syms  = 0;
      g     = n;
      while (nxt >= 0) begin
        t0  = nxt;
        nxt = -1;
        t1  = t0 + 1;
        while (t1 < n && ks[t1]) t1++;
        if (t1 >= n) begin
          g = n;
          break;
        end
        syms++;
        if (t1 + 1 < n) sym[t1+1] = ((t1 - t0) <= DOT_MAX) ? 2'b01 : 2'b10;
        lows = 0;
        g    = t1 + 1;
        while (g < n && lows < LETTER_GAP - 1) begin
          if (ks[g] && syms < MAX_SYMBOLS) begin
            nxt = g;
            break;
          end
          if (!ks[g]) lows++;
          g++;
        end
      end
      for (int i = first + 1; i <= g && i < n; i++) busy[i] = 1'b1;
      if (g >= n) break;
      letters++;
      if (g + 1 < n) sym[g+1] = 2'b11;
      for (int i = g + 1; i < n; i++) cnt[i] = 4'(letters);
      t = g + 1;
    end
    exp_q.delete();
    for (int i = 0; i < n; i++)
      exp_q.push_back({sym[i], cnt[i], (cnt[i] == 4'(MAX_LETTERS)), busy[i]});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus_if.key_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Replays kin[0..n-1] from reset, checking every cycle against the model.
  task automatic run_trace(input int n, input string tag,
                           output logic [15:0] seq, output int nsym);
    logic [7:0] exp_v;
    build_model(n);
    apply_reset();
    seq  = '0;
    nsym = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      check($sformatf("%s cyc%0d {sym,cnt,full,busy}", tag, t),
            {24'd0, bus_if.symbol_out, bus_if.letter_count, bus_if.full, bus_if.busy},
            {24'd0, exp_v});
      if (bus_if.symbol_out != 2'b00) begin
        if (nsym < 8) seq[2*nsym +: 2] = bus_if.symbol_out;
        nsym++;
      end
      bus_if.key_in = kin[t];
    end
  endtask

  function automatic int build_from_pat(input logic [63:0] pat);
    int n;
    int hi, lo;
    n = 0;
    kin[n++] = 1'b0;
    kin[n++] = 1'b0;
    for (int p = 0; p < 8; p++) begin
      hi = int'(pat[8*p+4 +: 4]);
      lo = int'(pat[8*p   +: 4]);
      if (hi == 0) break;
      for (int j = 0; j < hi; j++) kin[n++] = 1'b1;
      for (int j = 0; j < lo; j++) kin[n++] = 1'b0;
    end
    for (int j = 0; j < 16; j++) kin[n++] = 1'b0;
    return n;
  endfunction

  function automatic void gen_random(input int n);
    int i, h, l;
    kin[0] = 1'b0;
    kin[1] = 1'b0;
    i = 2;
    while (i < n) begin
      h = $urandom_range(1, 7);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 14) : $urandom_range(1, 7);
      for (int j = 0; j < h && i < n; j++) kin[i++] = 1'b1;
      for (int j = 0; j < l && i < n; j++) kin[i++] = 1'b0;
    end
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] seq;
    int          nsym, n;
    bit          seen;

    tbl[0] = '{64'h4C,         2, 16'h000D, 4'd1};  // dot, send
    tbl[1] = '{64'h5C,         2, 16'h000E, 4'd1};  // dash, send
    tbl[2] = '{64'h5C43,       3, 16'h0039, 4'd1};  // letter A
    tbl[3] = '{64'h3C33333333, 5, 16'h0355, 4'd1};  // fifth dot ignored
    tbl[4] = '{64'h4C48,       4, 16'h00DD, 4'd2};  // press on gap-complete cycle
    tbl[5] = '{64'h4C47,       3, 16'h0035, 4'd1};  // press one cycle before gap completes
    tbl[6] = '{64'h4C5C,       4, 16'h00DE, 4'd2};  // two letters
    tbl[7] = '{64'h6C636363,   5, 16'h03AA, 4'd1};  // four dashes

    reset         = 1'b1;
    bus_if.key_in = 1'b0;
    #12;
    check("reset_state", {28'd0, bus_if.symbol_out, bus_if.busy, bus_if.full},
          32'd0);
    check("reset_letter_count", {28'd0, bus_if.letter_count}, 32'd0);

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      n = build_from_pat(tbl[v].pat);
      run_trace(n, $sformatf("tbl%0d", v), seq, nsym);
      check($sformatf("tbl%0d symbols", v), {nsym[15:0], seq}, {tbl[v].nsym[15:0], tbl[v].seq});
      check($sformatf("tbl%0d letter_count", v), {28'd0, bus_if.letter_count}, {28'd0, tbl[v].cnt});
    end

    // Ten letters fill the decoder; an eleventh press produces nothing.
    n = 2;
    kin[0] = 1'b0;
    kin[1] = 1'b0;
    for (int l = 0; l < 11; l++) begin
      for (int j = 0; j < 3; j++)  kin[n++] = 1'b1;
      for (int j = 0; j < 12; j++) kin[n++] = 1'b0;
    end
    for (int j = 0; j < 16; j++) kin[n++] = 1'b0;
    run_trace(n, "ten_letters", seq, nsym);
    check("ten_letters symbol_count", nsym, 32'd20);
    check("ten_letters full/count", {27'd0, bus_if.full, bus_if.letter_count}, {27'd0, 1'b1, 4'd10});

    // Asynchronous reset between edges clears everything at once.
    #2 reset = 1'b1;
    #1 check("async_reset_after_full",
             {24'd0, bus_if.symbol_out, bus_if.letter_count, bus_if.full, bus_if.busy}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Reset pulsed in the middle of a press.
    apply_reset();
    @(negedge clk) bus_if.key_in = 1'b1;
    repeat (8) @(negedge clk);
    check("press_in_progress_busy", {31'd0, bus_if.busy}, 32'd1);
    #2 begin
      reset         = 1'b1;
      bus_if.key_in = 1'b0;
    end
    #1 check("reset_mid_press",
             {24'd0, bus_if.symbol_out, bus_if.letter_count, bus_if.full, bus_if.busy}, 32'd0);
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus_if.symbol_out != 2'b00 || bus_if.busy) seen = 1'b1;
    end
    check("no_symbol_after_mid_press_reset", {31'd0, seen}, 32'd0);

    // Two-cycle key pulse: filtered out with debounce, a dot without it.
    apply_reset();
    seq  = '0;
    nsym = 0;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (bus_if.symbol_out != 2'b00) begin
        if (nsym < 8) seq[2*nsym +: 2] = bus_if.symbol_out;
        nsym++;
      end
      bus_if.key_in = (t < 2);
    end
`ifdef MORSE_DEBOUNCE_EN
    check("glitch_filtered", {nsym[15:0], seq}, 32'd0);
`else
    check("short_press_dot", {nsym[15:0], seq}, {16'd2, 16'h000D});
`endif

    // Random key traces against the model.
    for (int r = 0; r < 6; r++) begin
      gen_random(500);
      run_trace(500, $sformatf("rand%0d", r), seq, nsym);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
